// File: rtl/qeciphy_tx_framer_pkg.sv
// qeciphy_tx_framer_pkg: shared types and CRC-32 helper for the TX framer.
// crc32_next is written in loop form over a bounded word so the same function
// serves any DATA_W up to CRC_MAX_W bits (pass the real width in nbits).
package qeciphy_tx_framer_pkg;

  typedef enum logic [2:0] {
    KIND_OFF  = 3'd0,
    KIND_FAW  = 3'd1,
    KIND_CRC  = 3'd2,
    KIND_DATA = 3'd3,
    KIND_IDLE = 3'd4
  } tx_kind_t;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_IDLE   = 2'd1,
    MODE_ACTIVE = 2'd2
  } tx_mode_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  localparam int unsigned CRC_MAX_W  = 512;
  localparam int unsigned CRC_IDX_W  = $clog2(CRC_MAX_W);

  // MSB-first, non-reflected CRC-32 step over the low nbits of data.
  function automatic logic [31:0] crc32_next(input logic [31:0]          crc,
                                             input logic [CRC_MAX_W-1:0] data,
                                             input int unsigned          nbits);
    logic [31:0]          c;
    logic                 fb;
    logic [CRC_IDX_W-1:0] idx;
    c = crc;
    for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
      if (i < nbits) begin
        idx = CRC_IDX_W'(nbits - 32'd1 - i);
        fb  = c[31] ^ data[idx];
        c   = {c[30:0], 1'b0};
        if (fb) c = c ^ CRC32_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/qeciphy_tx_framer_crc_accum.sv
// qeciphy_tx_crc_accum: CRC-32 accumulator, one DATA_W word per enabled cycle.
// init_i has priority over en_i and reloads the all-ones seed.
module qeciphy_tx_crc_accum
  import qeciphy_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [31:0]       crc_o
);

  // Seed on init, otherwise fold in the presented word when enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_o <= CRC32_INIT;
    end else if (init_i) begin
      crc_o <= CRC32_INIT;
    end else if (en_i) begin
      crc_o <= crc32_next(crc_o, CRC_MAX_W'(data_i), DATA_W);
    end
  end

endmodule

// File: rtl/qeciphy_tx_framer.sv
// qeciphy_tx_framer: self-timed TX framer. A free-running slot counter lays out
// FAW / data / CRC slots; mode is latched at slot 0 and held for the frame.
// Optional feature: define QECIPHY_TX_FRAMER_CRC_INJECT_EN to add inject_crc_err_i,
// which corrupts bit 0 of the next emitted (non-OFF) CRC word.
module qeciphy_tx_framer
  import qeciphy_tx_framer_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CRC_GROUP   = 6,
  parameter int unsigned       NUM_GROUPS  = 9,
  parameter logic [DATA_W-1:0] FAW_PATTERN = DATA_W'(64'hF6F6_2828_F6F6_2828),
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(64'h0707_0707_0707_0707)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_off_i,
  input  logic              tx_idle_i,
  input  logic              tx_active_i,
  input  logic              rx_rdy_i,
  input  logic [DATA_W-1:0] s_axis_tdata_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output tx_kind_t          m_axis_tkind_o,
  output logic              faw_boundary_o,
  output logic              crc_boundary_o
`ifdef QECIPHY_TX_FRAMER_CRC_INJECT_EN
  ,
  input  logic              inject_crc_err_i
`endif
);

  localparam int unsigned FAW_PERIOD = 1 + NUM_GROUPS * (CRC_GROUP + 1);
  localparam int unsigned SLOT_W     = $clog2(FAW_PERIOD);
  localparam int unsigned GRP_W      = $clog2(CRC_GROUP + 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [GRP_W-1:0]  grp_cnt;
  tx_mode_t          mode_q;
  tx_mode_t          req_mode;
  tx_mode_t          cur_mode;
  logic              is_faw;
  logic              is_crc;
  logic              is_data;
  logic              accept;
  logic              crc_init;
  logic              crc_en;
  logic              inj_flip;
  logic [DATA_W-1:0] data_word;
  logic [31:0]       crc_val;

  // Slot decode, mode selection and payload handshake.
  // grp_cnt tracks the position inside the current CRC group so no modulo of
  // slot_cnt is needed; slot 0 uses the freshly requested mode directly.
  always_comb begin
    is_faw  = (slot_cnt == '0);
    is_crc  = !is_faw && (grp_cnt == GRP_W'(CRC_GROUP));
    is_data = !is_faw && !is_crc;

    if (tx_off_i)         req_mode = MODE_OFF;
    else if (tx_idle_i)   req_mode = MODE_IDLE;
    else if (tx_active_i) req_mode = MODE_ACTIVE;
    else                  req_mode = MODE_OFF;

    cur_mode        = is_faw ? req_mode : mode_q;
    s_axis_tready_o = is_data && (mode_q == MODE_ACTIVE);
    accept          = s_axis_tready_o && s_axis_tvalid_i;
    data_word       = accept ? s_axis_tdata_i : IDLE_WORD;
    crc_init        = is_faw || is_crc;
    crc_en          = is_data && (mode_q != MODE_OFF);
  end

  // Free-running slot/group counters and per-frame mode latch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt <= '0;
      grp_cnt  <= '0;
      mode_q   <= MODE_OFF;
    end else begin
      slot_cnt <= (slot_cnt == SLOT_W'(FAW_PERIOD - 1)) ? '0 : slot_cnt + SLOT_W'(1);
      if (crc_init) grp_cnt <= '0;
      else          grp_cnt <= grp_cnt + GRP_W'(1);
      if (is_faw)   mode_q  <= req_mode;
    end
  end

  qeciphy_tx_crc_accum #(
    .DATA_W (DATA_W)
  ) u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (data_word),
    .crc_o  (crc_val)
  );

`ifdef QECIPHY_TX_FRAMER_CRC_INJECT_EN
  logic inj_armed;

  // Sticky error request, consumed by the next CRC slot of a non-OFF frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inj_armed <= 1'b0;
    else       inj_armed <= inject_crc_err_i | (inj_armed & ~(is_crc && (mode_q != MODE_OFF)));
  end

  // Flip only on a CRC slot that actually emits a CRC word.
  always_comb begin
    inj_flip = inj_armed && is_crc && (mode_q != MODE_OFF);
  end
`else
  // CRC words are always emitted unmodified.
  always_comb begin
    inj_flip = 1'b0;
  end
`endif

  // Registered line word, kind and boundary markers for the current slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tdata_o <= '0;
      m_axis_tkind_o <= KIND_OFF;
      faw_boundary_o <= 1'b0;
      crc_boundary_o <= 1'b0;
    end else begin
      faw_boundary_o <= is_faw;
      crc_boundary_o <= is_crc;
      if (cur_mode == MODE_OFF) begin
        m_axis_tdata_o <= '0;
        m_axis_tkind_o <= KIND_OFF;
      end else if (is_faw) begin
        m_axis_tdata_o <= {FAW_PATTERN[DATA_W-1:1], rx_rdy_i};
        m_axis_tkind_o <= KIND_FAW;
      end else if (is_crc) begin
        m_axis_tdata_o <= DATA_W'(crc_val) ^ DATA_W'(inj_flip);
        m_axis_tkind_o <= KIND_CRC;
      end else begin
        m_axis_tdata_o <= data_word;
        m_axis_tkind_o <= accept ? KIND_DATA : KIND_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// tb_qeciphy_tx_framer: directed bench for qeciphy_tx_framer (default parameters).
// Each slot: drive inputs, check tready, clock once, check the registered word.
`timescale 1ns/1ps
module tb_qeciphy_tx_framer;
  import qeciphy_tx_framer_pkg::*;

  localparam logic [63:0] FAW_PAT = 64'hF6F6_2828_F6F6_2828;
  localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_off, tx_idle, tx_active, rx_rdy;
  logic        tvalid, tready, faw_b, crc_b, inject;
  logic [63:0] tdata_in, tdata_out;
  tx_kind_t    tkind;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          beats    = 0;
  logic [31:0] ref_crc;
  logic        inj_pending;

  always #5 clk = ~clk;

  qeciphy_tx_framer #(
    .DATA_W     (64),
    .CRC_GROUP  (6),
    .NUM_GROUPS (9)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tx_off_i        (tx_off),
    .tx_idle_i       (tx_idle),
    .tx_active_i     (tx_active),
    .rx_rdy_i        (rx_rdy),
    .s_axis_tdata_i  (tdata_in),
    .s_axis_tvalid_i (tvalid),
    .s_axis_tready_o (tready),
    .m_axis_tdata_o  (tdata_out),
    .m_axis_tkind_o  (tkind),
    .faw_boundary_o  (faw_b),
    .crc_boundary_o  (crc_b)
`ifdef QECIPHY_TX_FRAMER_CRC_INJECT_EN
    ,
    .inject_crc_err_i(inject)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " tdata"},  tdata_out, 64'h0);
    chk({tag, " tkind"},  64'(tkind), 64'(KIND_OFF));
    chk({tag, " faw_b"},  64'(faw_b), 64'h0);
    chk({tag, " crc_b"},  64'(crc_b), 64'h0);
    chk({tag, " tready"}, 64'(tready), 64'h0);
  endtask

  // One slot s of a frame whose mode the bench expects to be m.
  task automatic do_slot(input int unsigned s, input tx_mode_t m);
    logic        faw, crcs, dat, acc, flip;
    logic [63:0] w;
    tx_kind_t    k;
    faw  = (s == 0);
    crcs = (s != 0) && (s % 7 == 0);
    dat  = !faw && !crcs;
    acc  = dat && (m == MODE_ACTIVE) && tvalid;
    flip = 1'b0;
    if (m == MODE_OFF) begin
      w = 64'h0;                     k = KIND_OFF;
    end else if (faw) begin
      w = {FAW_PAT[63:1], rx_rdy};   k = KIND_FAW;
    end else if (crcs) begin
      flip = inj_pending;
      w = {32'h0, ref_crc ^ {31'h0, flip}};  k = KIND_CRC;
    end else begin
      w = acc ? tdata_in : IDLE_W;   k = acc ? KIND_DATA : KIND_IDLE;
    end
    if (faw || crcs)        ref_crc = CRC32_INIT;
    else if (m != MODE_OFF) ref_crc = crc32_next(ref_crc, CRC_MAX_W'(w), 64);
    if (crcs && (m != MODE_OFF)) inj_pending = 1'b0;
    if (inject)                  inj_pending = 1'b1;

    chk($sformatf("tready s%0d", s), 64'(tready), 64'(dat && (m == MODE_ACTIVE)));
    if (tready && tvalid) beats++;
    step();
    chk($sformatf("tdata s%0d", s), tdata_out, w);
    chk($sformatf("tkind s%0d", s), 64'(tkind), 64'(k));
    chk($sformatf("faw_b s%0d", s), 64'(faw_b), 64'(faw));
    chk($sformatf("crc_b s%0d", s), 64'(crc_b), 64'(crcs));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tx_off = 1'b1; tx_idle = 1'b0; tx_active = 1'b0; rx_rdy = 1'b0;
    tvalid = 1'b0; tdata_in = 64'h0; inject = 1'b0;
    ref_crc = CRC32_INIT; inj_pending = 1'b0;

    // Reset state
    step();
    chk_reset_state("reset");
    rst = 1'b0;

    // OFF held for two frames: zero words, boundaries still on schedule
    for (int unsigned i = 0; i < 128; i++) do_slot(i % 64, MODE_OFF);

    // IDLE frame, rx ready advertised in FAW bit 0
    tx_off = 1'b0; tx_idle = 1'b1; rx_rdy = 1'b1;
    for (int unsigned s = 0; s < 64; s++) do_slot(s, MODE_IDLE);

    // ACTIVE, tvalid always high, incrementing payload 1..54
    tx_idle = 1'b0; tx_active = 1'b1; rx_rdy = 1'b0; tvalid = 1'b1; beats = 0;
    for (int unsigned s = 0; s < 64; s++) begin
      tdata_in = 64'(beats + 1);
      do_slot(s, MODE_ACTIVE);
    end
    chk("beats per frame", 64'(beats), 64'd54);

    // ACTIVE, sparse valid; beat held across CRC slot 7 goes out in slot 8
    for (int unsigned s = 0; s < 64; s++) begin
      tvalid   = (s == 3) || (s == 4) || (s == 7) || (s == 8);
      tdata_in = (s >= 7) ? 64'hC0DE_0000_0000_C0DE : 64'hA000 + 64'(s);
      do_slot(s, MODE_ACTIVE);
    end

    // IDLE frame with active requested mid-frame: takes effect next slot 0
    tx_idle = 1'b1; tx_active = 1'b0; tvalid = 1'b1; rx_rdy = 1'b1;
    for (int unsigned s = 0; s < 64; s++) begin
      if (s == 20) begin tx_idle = 1'b0; tx_active = 1'b1; end
      tdata_in = 64'h5500 + 64'(s);
      do_slot(s, MODE_IDLE);
    end
    for (int unsigned s = 0; s < 30; s++) begin
      tdata_in = 64'h6600 + 64'(s);
      do_slot(s, MODE_ACTIVE);
    end

    // Asynchronous reset at slot 30 for 3 cycles, then restart at slot 0
    rst = 1'b1;
    #1;
    chk_reset_state("async reset");
    step(); step(); step();
    rst = 1'b0;
    ref_crc = CRC32_INIT; inj_pending = 1'b0;
    for (int unsigned s = 0; s < 64; s++) begin
`ifdef QECIPHY_TX_FRAMER_CRC_INJECT_EN
      inject = (s == 2);
`endif
      tdata_in = 64'hDEAD_0000 + 64'(s);
      do_slot(s, MODE_ACTIVE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
